// File: rtl/regfile_pkg.sv
// Shared select-map helpers and constants for the vector register file.
// Regions: vector, then scalar, then three read-only specials.
package regfile_pkg;

    localparam int SPEC_ZERO   = 0;
    localparam int SPEC_LANEID = 1;
    localparam int SPEC_CYCLE  = 2;
    localparam int SPEC_COUNT  = 3;

    localparam int DEF_REG_SIZE = 8;
    localparam int DEF_VEC_SIZE = 4;

    typedef logic [DEF_VEC_SIZE-1:0][DEF_REG_SIZE-1:0] laneVec_t;

    function automatic int vecBase();
        return 0;
    endfunction

    function automatic int scBase(int vecQ);
        return vecQ;
    endfunction

    function automatic int specBase(int vecQ, int scQ);
        return vecQ + scQ;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: select decode, scalar broadcast
// and optional same-cycle write forwarding.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int registerSize   = 8,
    parameter int vectorSize     = 4,
    parameter int vecRegQuantity = 8,
    parameter int scRegQuantity  = 4,
    parameter int selectionBits  = 4,
    parameter bit BYPASS         = 1'b1
) (
    input  logic [selectionBits-1:0] rSel,
    input  logic [vecRegQuantity-1:0][vectorSize-1:0][registerSize-1:0] vecRegs,
    input  logic [scRegQuantity-1:0][registerSize-1:0] scRegs,
    input  logic [vectorSize*registerSize-1:0] cycleCnt,
    input  logic wrVec,
    input  logic wrSc,
    input  logic [selectionBits-1:0] wrSel,
    input  logic [vectorSize-1:0][registerSize-1:0] wrData,
    input  logic [vectorSize-1:0] laneMask,
    output logic [vectorSize-1:0][registerSize-1:0] operand
);

    localparam int SB = selectionBits;
    localparam int SPEC = specBase(vecRegQuantity, scRegQuantity);

    logic fwd;
    logic [registerSize-1:0] elem;

    assign fwd = BYPASS && (wrSel == rSel);

    always_comb begin
        operand = '0;
        elem = '0;
        for (int i = 0; i < vecRegQuantity; i++) begin
            if (rSel == SB'(vecBase() + i)) begin
                operand = vecRegs[i];
                if (fwd && wrVec) begin
                    for (int l = 0; l < vectorSize; l++) begin
                        if (laneMask[l]) operand[l] = wrData[l];
                    end
                end
            end
        end
        for (int j = 0; j < scRegQuantity; j++) begin
            if (rSel == SB'(scBase(vecRegQuantity) + j)) begin
                elem = (fwd && wrSc) ? wrData[0] : scRegs[j];
                for (int l = 0; l < vectorSize; l++) operand[l] = elem;
            end
        end
        if (rSel == SB'(SPEC + SPEC_LANEID)) begin
            for (int l = 0; l < vectorSize; l++) operand[l] = registerSize'(l);
        end
        if (rSel == SB'(SPEC + SPEC_CYCLE)) operand = cycleCnt;
    end

endmodule

// File: rtl/vec_reg_file_v2.sv
// Vector/scalar/special register file with masked writes, bypass
// and a sticky illegal-write flag.
module vec_reg_file_v2
    import regfile_pkg::*;
#(
    parameter int registerSize   = 8,
    parameter int vectorSize     = 4,
    parameter int vecRegQuantity = 8,
    parameter int scRegQuantity  = 4,
    parameter int selectionBits  = 4,
    parameter bit BYPASS         = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic regWrEnVec,
    input  logic regWrEnSc,
    input  logic [vectorSize-1:0] laneMask,
    input  logic [selectionBits-1:0] regToWrite,
    input  logic [vectorSize-1:0][registerSize-1:0] dataIn,
    input  logic [selectionBits-1:0] rSel1,
    input  logic [selectionBits-1:0] rSel2,
    output logic [vectorSize-1:0][registerSize-1:0] operand1,
    output logic [vectorSize-1:0][registerSize-1:0] operand2,
    output logic wrErr
);

    localparam int SB = selectionBits;
    localparam int CW = vectorSize * registerSize;
    localparam int SCB = scBase(vecRegQuantity);
    localparam int SPB = specBase(vecRegQuantity, scRegQuantity);

    if ((2 ** selectionBits) < SPB + SPEC_COUNT) begin : gSelCheck
        $error("selectionBits too small for register map");
    end

    logic [vecRegQuantity-1:0][vectorSize-1:0][registerSize-1:0] vecRegs;
    logic [scRegQuantity-1:0][registerSize-1:0] scRegs;
    logic [CW-1:0] cycleCnt;

    logic isVec, isSc, wrVec, wrSc, wrIllegal;

    assign isVec = regToWrite < SB'(SCB);
    assign isSc = (regToWrite >= SB'(SCB)) && (regToWrite < SB'(SPB));
    assign wrVec = regWrEnVec && !regWrEnSc && isVec;
    assign wrSc = regWrEnSc && !regWrEnVec && isSc;
    assign wrIllegal = (regWrEnVec || regWrEnSc) && !wrVec && !wrSc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vecRegs <= '0;
            scRegs <= '0;
            cycleCnt <= '0;
            wrErr <= 1'b0;
        end else begin
            cycleCnt <= cycleCnt + CW'(1);
            if (wrIllegal) wrErr <= 1'b1;
            for (int i = 0; i < vecRegQuantity; i++) begin
                if (wrVec && regToWrite == SB'(vecBase() + i)) begin
                    for (int l = 0; l < vectorSize; l++) begin
                        if (laneMask[l]) vecRegs[i][l] <= dataIn[l];
                    end
                end
            end
            for (int j = 0; j < scRegQuantity; j++) begin
                if (wrSc && regToWrite == SB'(SCB + j)) scRegs[j] <= dataIn[0];
            end
        end
    end

    regfile_read_port #(
        .registerSize(registerSize), .vectorSize(vectorSize),
        .vecRegQuantity(vecRegQuantity), .scRegQuantity(scRegQuantity),
        .selectionBits(selectionBits), .BYPASS(BYPASS)
    ) uPort1 (
        .rSel(rSel1), .vecRegs(vecRegs), .scRegs(scRegs),
        .cycleCnt(cycleCnt), .wrVec(wrVec), .wrSc(wrSc),
        .wrSel(regToWrite), .wrData(dataIn), .laneMask(laneMask),
        .operand(operand1)
    );

    regfile_read_port #(
        .registerSize(registerSize), .vectorSize(vectorSize),
        .vecRegQuantity(vecRegQuantity), .scRegQuantity(scRegQuantity),
        .selectionBits(selectionBits), .BYPASS(BYPASS)
    ) uPort2 (
        .rSel(rSel2), .vecRegs(vecRegs), .scRegs(scRegs),
        .cycleCnt(cycleCnt), .wrVec(wrVec), .wrSc(wrSc),
        .wrSel(regToWrite), .wrData(dataIn), .laneMask(laneMask),
        .operand(operand2)
    );

endmodule
